// File: rtl/xor_descrambler.sv
// xor_descrambler: self-synchronising 1+x^6+x^7 descrambler with
// HUNT/LOCKED framing on SYNC_WORD and a one-beat output register.
// Ports: clk, rst (sync, active-high); in_data/in_valid/in_ready
// scrambled input stream; out_data/out_valid/out_ready payload
// stream; locked (FSM in LOCKED); sync_pulse (sync beat seen).
// Optional: define DESCR_LOCK_LOSS_EN to drop lock after more than
// MAX_GAP consecutive non-sync beats.
module xor_descrambler #(
  parameter int W = 8,
  parameter logic [W-1:0] SYNC_WORD = W'(8'hA5),
  parameter int MAX_GAP = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         locked,
  output logic         sync_pulse
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [6:0]   r_sr;
  logic [6:0]   w_sr_nxt;
  logic [W-1:0] w_d;
  logic [W-1:0] r_out_data;
  logic         r_out_valid;
  logic         r_sync;
  logic         w_acc;
  logic         w_match;
  logic         w_fwd;
  logic         w_sync;

  assign in_ready   = !r_out_valid || out_ready;
  assign w_acc      = in_valid && in_ready;
  assign out_data   = r_out_data;
  assign out_valid  = r_out_valid;
  assign locked     = (r_state == LOCKED);
  assign sync_pulse = r_sync;

  // Bits are descrambled earliest-first; the register always shifts
  // in the received (scrambled) bit, which is what makes it
  // self-synchronising.
  always_comb begin : descramble
    logic [6:0] v_sr;
    v_sr = r_sr;
    w_d  = '0;
    for (int i = 0; i < W; i++) begin
      w_d[i] = in_data[i] ^ v_sr[5] ^ v_sr[6];
      v_sr   = {v_sr[5:0], in_data[i]};
    end
    w_sr_nxt = v_sr;
  end

  assign w_match = (w_d == SYNC_WORD);

`ifdef DESCR_LOCK_LOSS_EN
  localparam int GW = $clog2(MAX_GAP + 2);

  logic [GW-1:0] r_gap;
  logic [GW-1:0] w_gap_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_gap_nxt   = r_gap;
    w_fwd       = 1'b0;
    w_sync      = 1'b0;
    if (w_acc) begin
      w_sync = w_match;
      case (r_state)
        HUNT: begin
          if (w_match) begin
            w_state_nxt = LOCKED;
            w_gap_nxt   = '0;
          end
        end
        LOCKED: begin
          if (w_match) begin
            w_gap_nxt = '0;
          end else if (r_gap == GW'(MAX_GAP)) begin
            // This beat would exceed the gap budget: drop it and
            // re-hunt, keeping sr so resync can start immediately.
            w_state_nxt = HUNT;
            w_gap_nxt   = '0;
          end else begin
            w_gap_nxt = r_gap + 1'b1;
            w_fwd     = 1'b1;
          end
        end
        default: w_state_nxt = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gap <= '0;
    end else begin
      r_gap <= w_gap_nxt;
    end
  end
`else
  logic w_unused_gap;
  assign w_unused_gap = (MAX_GAP > 0);

  always_comb begin
    w_state_nxt = r_state;
    w_fwd       = 1'b0;
    w_sync      = 1'b0;
    if (w_acc) begin
      w_sync = w_match;
      case (r_state)
        HUNT: begin
          if (w_match) begin
            w_state_nxt = LOCKED;
          end
        end
        LOCKED: begin
          w_fwd = !w_match;
        end
        default: w_state_nxt = HUNT;
      endcase
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= HUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Output register only reloads when the sink can take data, so a
  // held beat stays stable; a non-forwarded cycle lets it drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr        <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_sync      <= 1'b0;
    end else begin
      r_sync <= w_sync;
      if (w_acc) begin
        r_sr <= w_sr_nxt;
      end
      if (in_ready) begin
        r_out_valid <= w_fwd;
        if (w_fwd) begin
          r_out_data <= w_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_xor_descrambler.sv
// tb_xor_descrambler: scrambles plaintext with a transmit-side model
// and checks the descrambler against an expected-payload queue.
module tb_xor_descrambler;

  localparam int MAXG = 4;
  localparam logic [7:0] SYNC = 8'hA5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       locked;
  logic       sync_pulse;

  int n_checks = 0;
  int n_fail = 0;

  logic [6:0] tx = '0;
  logic [7:0] cur_plain = '0;
  logic       m_locked = 1'b0;
  int         m_gap = 0;
  logic       m_sp = 1'b0;
  logic [7:0] q[$];

  xor_descrambler #(
    .W(8),
    .SYNC_WORD(SYNC),
    .MAX_GAP(MAXG)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .locked(locked),
    .sync_pulse(sync_pulse)
  );

  always #5 clk = ~clk;

  // Transmit scrambler: s = p ^ t6 ^ t7, state shifts in s.
  function automatic logic [14:0] scr(input logic [7:0] p,
                                      input logic [6:0] t);
    logic [6:0] st;
    logic [7:0] s;
    st = t;
    s  = '0;
    for (int i = 0; i < 8; i++) begin
      s[i] = p[i] ^ st[5] ^ st[6];
      st   = {st[5:0], s[i]};
    end
    return {st, s};
  endfunction

  task automatic set_beat(input logic [7:0] p);
    logic [14:0] r;
    cur_plain = p;
    r = scr(p, tx);
    in_data = r[7:0];
    in_valid = 1'b1;
  endtask

  // One clock: sample handshakes mid-cycle, then advance the model.
  task automatic tick();
    logic acc;
    logic oh;
    logic [7:0] p;
    logic [14:0] r;
    @(negedge clk);
    acc = in_valid && in_ready && !rst;
    oh  = out_valid && out_ready && !rst;
    p   = cur_plain;
    @(posedge clk);
    #1;
    m_sp = 1'b0;
    if (rst) begin
      m_locked = 1'b0;
      m_gap = 0;
      q.delete();
      tx = '0;
    end else begin
      if (oh && q.size() > 0) void'(q.pop_front());
      if (acc) begin
        r = scr(p, tx);
        tx = r[14:8];
        if (p == SYNC) begin
          m_sp = 1'b1;
          m_locked = 1'b1;
          m_gap = 0;
        end else if (m_locked) begin
`ifdef DESCR_LOCK_LOSS_EN
          if (m_gap == MAXG) begin
            m_locked = 1'b0;
            m_gap = 0;
          end else begin
            m_gap++;
            q.push_back(p);
          end
`else
          q.push_back(p);
`endif
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 8'($urandom);
    tick();
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_out_valid got=%b exp=0", out_valid);
    end
    n_checks++;
    if (locked !== 1'b0 || sync_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_lock_sync got=%b%b exp=00",
               locked, sync_pulse);
    end
    n_checks++;
    if (out_data !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_out_data got=%h exp=00", out_data);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    tick();
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_in_ready got=%b exp=1", in_ready);
    end
  endtask

  task automatic test_lock();
    logic [7:0] pl[5];
    logic       ev[5];
    logic       es[5];
    pl = '{8'h00, 8'hA5, 8'h11, 8'h22, 8'h33};
    ev = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    es = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_beat(pl[i]);
      tick();
      n_checks++;
      if (out_valid !== ev[i] || (ev[i] && out_data !== pl[i])) begin
        n_fail++;
        $display("FAIL lock_out[%0d] got=%b/%h exp=%b/%h",
                 i, out_valid, out_data, ev[i], pl[i]);
      end
      n_checks++;
      if (sync_pulse !== es[i] || locked !== (i >= 1)) begin
        n_fail++;
        $display("FAIL lock_state[%0d] got sp=%b lk=%b", i,
                 sync_pulse, locked);
      end
    end
    in_valid = 1'b0;
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_drain got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b1;
    set_beat(8'h44);
    tick();
    out_ready = 1'b0;
    set_beat(8'h55);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h44 ||
          in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d] got v=%b d=%h rdy=%b exp 1/44/0",
                 i, out_valid, out_data, in_ready);
      end
    end
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h55) begin
      n_fail++;
      $display("FAIL bp_55 got=%b/%h exp=1/55", out_valid, out_data);
    end
    set_beat(8'h66);
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h66) begin
      n_fail++;
      $display("FAIL bp_66 got=%b/%h exp=1/66", out_valid, out_data);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_midsync();
    logic [7:0] pl[3];
    int nsp;
    pl = '{8'h77, 8'hA5, 8'h88};
    nsp = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_beat(pl[i]);
      tick();
      if (sync_pulse === 1'b1) nsp++;
      n_checks++;
      if (i != 1 && (out_valid !== 1'b1 || out_data !== pl[i])) begin
        n_fail++;
        $display("FAIL mid_out[%0d] got=%b/%h exp=1/%h",
                 i, out_valid, out_data, pl[i]);
      end else if (i == 1 && out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_drop got=%b exp=0", out_valid);
      end
    end
    in_valid = 1'b0;
    tick();
    if (sync_pulse === 1'b1) nsp++;
    n_checks++;
    if (nsp != 1) begin
      n_fail++;
      $display("FAIL mid_sync_count got=%0d exp=1", nsp);
    end
  endtask

  task automatic test_lock_loss();
    int nf;
    int exp_nf;
    logic exp_lk;
`ifdef DESCR_LOCK_LOSS_EN
    exp_nf = MAXG;
    exp_lk = 1'b0;
`else
    exp_nf = 5;
    exp_lk = 1'b1;
`endif
    nf = 0;
    out_ready = 1'b1;
    set_beat(SYNC);
    tick();
    for (int k = 1; k <= 5; k++) begin
      set_beat(8'(k));
      tick();
      if (out_valid === 1'b1) begin
        nf++;
        n_checks++;
        if (out_data !== 8'(k)) begin
          n_fail++;
          $display("FAIL gap_data[%0d] got=%h exp=%h", k, out_data,
                   8'(k));
        end
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (nf != exp_nf) begin
      n_fail++;
      $display("FAIL gap_fwd got=%0d exp=%0d", nf, exp_nf);
    end
    n_checks++;
    if (locked !== exp_lk) begin
      n_fail++;
      $display("FAIL gap_locked got=%b exp=%b", locked, exp_lk);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    set_beat(SYNC);
    tick();
    out_ready = 1'b0;
    set_beat(8'h99);
    tick();
    set_beat(8'h5A);
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h99) begin
      n_fail++;
      $display("FAIL rmid_held got=%b/%h exp=1/99", out_valid, out_data);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || locked !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_clear got v=%b lk=%b exp 0/0",
               out_valid, locked);
    end
    tick();
    out_ready = 1'b1;
    set_beat(SYNC);
    tick();
    n_checks++;
    if (locked !== 1'b1 || sync_pulse !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_relock got lk=%b sp=%b exp 1/1",
               locked, sync_pulse);
    end
    set_beat(8'h12);
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h12) begin
      n_fail++;
      $display("FAIL rmid_fwd got=%b/%h exp=1/12", out_valid, out_data);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic ev;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 7) == 0) set_beat(SYNC);
      else set_beat(8'($urandom));
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
      ev = (q.size() != 0);
      n_checks++;
      if (out_valid !== ev || (ev && out_data !== q[0])) begin
        n_fail++;
        $display("FAIL rnd_out[%0d] got=%b/%h exp=%b/%h", c,
                 out_valid, out_data, ev, ev ? q[0] : 8'h00);
      end
      n_checks++;
      if (locked !== m_locked || sync_pulse !== m_sp) begin
        n_fail++;
        $display("FAIL rnd_state[%0d] got lk=%b sp=%b exp %b/%b", c,
                 locked, sync_pulse, m_locked, m_sp);
      end
      n_checks++;
      if (in_ready !== (!ev || out_ready)) begin
        n_fail++;
        $display("FAIL rnd_ready[%0d] got=%b exp=%b", c, in_ready,
                 !ev || out_ready);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_lock();
    test_backpressure();
    test_midsync();
    test_lock_loss();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
